// File: rtl/mult16_seq.sv
// Sequential 16x16 unsigned shift-and-add multiplier with a start/busy/done handshake.
// Each RUN cycle performs one add-and-shift through a single 16-bit ripple adder.

module fulladder16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] s,
  output logic        cout
);
  logic [16:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < 16; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[16];
endmodule

module mult16_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] mcand;
  logic [15:0] acc_hi;
  logic [15:0] acc_lo;
  logic [3:0]  cnt;
  logic [15:0] addend;
  logic [15:0] sum;
  logic        cout;
  logic [31:0] acc_nxt;

  assign addend = acc_lo[0] ? mcand : 16'h0;

  fulladder16 u_add (
    .a    (acc_hi),
    .b    (addend),
    .s    (sum),
    .cout (cout)
  );

  // The adder's carry becomes the new top bit, so the 33-bit partial sum survives the shift.
  assign acc_nxt = {cout, sum, acc_lo[15:1]};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == 4'd15) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= 16'h0;
      acc_hi  <= 16'h0;
      acc_lo  <= 16'h0;
      cnt     <= 4'd0;
      product <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= a;
            acc_hi <= 16'h0;
            acc_lo <= b;
            cnt    <= 4'd0;
          end
        end
        RUN: begin
          {acc_hi, acc_lo} <= acc_nxt;
          cnt              <= cnt + 4'd1;
          if (cnt == 4'd15) product <= acc_nxt;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mult16_seq.sv
// Self-checking bench for mult16_seq: directed vector table, handshake corner cases,
// and a long back-to-back random run scored against plain a*b arithmetic.

module tb_mult16_seq;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int n_checks;
  int n_fail;

  mult16_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic [31:0] exp;
  } vec_t;

  // Edge count from the accept edge to the edge that raises done (done is seen in
  // the 17th cycle counting the accept cycle), and the done-to-done spacing when
  // start is held high: the DONE cycle ignores start, so the next accept is one
  // edge after returning to IDLE.
  localparam int DONE_EDGES = 16;
  localparam int B2B_PERIOD = 18;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y);
    return {16'h0, x} * {16'h0, y};
  endfunction

  // Accept one operation from IDLE and follow it to completion, checking timing and result.
  task automatic do_mult(input logic [15:0] va, input logic [15:0] vb,
                         input logic [31:0] exp, input string name);
    int k;
    int busy_cnt;
    bit seen;
    @(negedge clk);
    a = va; b = vb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 16'h5a5a; b = 16'ha5a5;
    k = 0; busy_cnt = 0; seen = 0;
    while (k < 40) begin
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1;
        break;
      end
      @(negedge clk);
      k++;
    end
    check({name, " done_seen"}, 32'(seen), 32'd1);
    check({name, " latency"}, 32'(k), 32'(DONE_EDGES));
    check({name, " busy_cycles"}, 32'(busy_cnt), 32'd16);
    check({name, " busy_in_done"}, 32'(busy), 32'd0);
    check({name, " product"}, product, exp);
    @(negedge clk);
    check({name, " done_single"}, 32'(done), 32'd0);
    check({name, " product_hold"}, product, exp);
  endtask

  vec_t vecs[$];

  initial begin
    int k;
    int done_cnt;
    int hold_err;
    int since;
    logic [31:0] last_prod;
    logic [31:0] expq[$];
    logic [15:0] ra;
    logic [15:0] rb;

    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0; start = 1'b0; a = 16'h0; b = 16'h0;

    vecs.push_back('{16'h0003, 16'h0005, 32'h0000000F});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 32'hFFFE0001});
    vecs.push_back('{16'h8000, 16'h0002, 32'h00010000});
    vecs.push_back('{16'h0000, 16'h1234, 32'h00000000});
    vecs.push_back('{16'hABCD, 16'h0001, 32'h0000ABCD});
    vecs.push_back('{16'hFFFF, 16'h8000, 32'h7FFF8000});
    for (int i = 0; i < 4; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      vecs.push_back('{ra, rb, model(ra, rb)});
    end

    // Reset state
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset product", product, 32'h0);
    rst_n = 1'b1;

    foreach (vecs[i]) do_mult(vecs[i].va, vecs[i].vb, vecs[i].exp, $sformatf("vec%0d", i));

    // Start pulses during RUN and during DONE are lost.
    @(negedge clk);
    a = 16'd7; b = 16'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (k < 40 && !done) begin
      if (k == 5) begin
        a = 16'd2; b = 16'd2; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    check("ignore done_edge", 32'(k), 32'(DONE_EDGES));
    check("ignore product", product, 32'd63);
    a = 16'd2; b = 16'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      if (done || busy) done_cnt++;
      @(negedge clk);
    end
    check("ignore stays_idle", 32'(done_cnt), 32'd0);
    check("ignore product_kept", product, 32'd63);

    // Asynchronous reset mid-RUN.
    a = 16'd100; b = 16'd200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("abort busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort product", product, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      if (done || busy) done_cnt++;
      @(negedge clk);
    end
    check("abort no_done", 32'(done_cnt), 32'd0);
    do_mult(16'd10, 16'd10, 32'd100, "after_abort");

    // Back-to-back random run with start held high.
    ra = 16'($urandom); rb = 16'($urandom);
    a = ra; b = rb; start = 1'b1;
    expq.push_back(model(ra, rb));
    done_cnt = 0; hold_err = 0; since = 0;
    last_prod = product;
    k = 0;
    while (done_cnt < 1000 && k < 1000 * B2B_PERIOD + 200) begin
      @(negedge clk);
      k++; since++;
      if (done) begin
        check($sformatf("b2b product %0d", done_cnt), product, expq.pop_front());
        if (done_cnt > 0) check($sformatf("b2b period %0d", done_cnt), 32'(since), 32'(B2B_PERIOD));
        since = 0;
        last_prod = product;
        done_cnt++;
        ra = 16'($urandom); rb = 16'($urandom);
        if (done_cnt == 999) begin
          ra = 16'hFFFF; rb = 16'hFFFF;
        end
        a = ra; b = rb;
        expq.push_back(model(ra, rb));
      end else if (product !== last_prod) begin
        hold_err++;
      end
    end
    start = 1'b0;
    check("b2b completed", 32'(done_cnt), 32'd1000);
    check("b2b product_hold", 32'(hold_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
